comp_minmax_tracker: RTL and testbench
======================================

Name: comp_minmax_tracker

Overview:
- Streaming min/max search stage. It sits around one COMP instance: it drives the comparator's a/b inputs and consumes its gt/lt/eq flags.
- Accepts a framed stream of unsigned samples over a valid/ready handshake. Tracks the running minimum and maximum, plus the in-frame index of each.
- Presents the frame result on a valid/ready output port when the frame's last sample has been processed.
- The comparator is shared: one max compare and one min compare per sample, sequenced by an FSM.

Parameters:
- DATAWIDTH, 8, sample width; must equal the DATAWIDTH of the attached COMP.
- IDXWIDTH, 8, width of the in-frame sample index.

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  asynchronous reset, active-low (0 = reset).
- in_data  input  DATAWIDTH  sample.
- in_valid  input  1  sample present.
- in_last  input  1  sample is the last of the frame; qualified by in_valid.
- in_ready  output  1  block can accept a sample.
- cmp_a  output  DATAWIDTH  to COMP a.
- cmp_b  output  DATAWIDTH  to COMP b.
- cmp_gt  input  1  from COMP gt.
- cmp_lt  input  1  from COMP lt.
- cmp_eq  input  1  from COMP eq.
- out_min  output  DATAWIDTH  frame minimum.
- out_max  output  DATAWIDTH  frame maximum.
- out_min_idx  output  IDXWIDTH  index of the first occurrence of the minimum.
- out_max_idx  output  IDXWIDTH  index of the first occurrence of the maximum.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts the result.

Behaviour:
- FSM states: ACCEPT, CMP_MAX, CMP_MIN, DONE. Reset state is ACCEPT.
- Reset values:
  - All outputs are 0 (out_*, cmp_a, cmp_b).
  - Internal sample, min, max, index and count registers are 0; last flag is cleared.
  - in_ready is 0 during reset. After reset release it follows the state.
- in_ready = 1 only in ACCEPT. A transfer occurs on a rising edge with in_valid & in_ready.
- ACCEPT, on transfer:
  - Latch sample into smp and in_last into lst; idx = count; count increments.
  - First sample of frame (count == 0): min = max = sample, min_idx = max_idx = 0. Go to DONE if in_last, else stay in ACCEPT (no compare needed).
  - Otherwise go to CMP_MAX.
- CMP_MAX:
  - cmp_a = smp, cmp_b = max; flags are sampled in the same cycle.
  - If cmp_gt: max = smp, max_idx = idx.
  - Go to CMP_MIN.
- CMP_MIN:
  - cmp_a = smp, cmp_b = min.
  - If cmp_lt: min = smp, min_idx = idx.
  - Go to DONE if lst, else ACCEPT.
- Ties (cmp_eq) never update, so the earliest index wins.
- cmp_a and cmp_b are 0 in ACCEPT and DONE. They depend only on registered state, so there is no combinational loop through COMP.
- DONE:
  - Output registers are loaded on entry; out_valid = 1 and is held stable until out_ready.
  - On out_valid & out_ready: out_valid falls next cycle, count = 0, go to ACCEPT.
- Throughput: 3 cycles per non-first sample, 1 cycle for the first. Latency from the last-sample transfer to out_valid: 3 cycles, or 1 cycle for a single-sample frame.
- The index counter wraps modulo 2^IDXWIDTH. The frame continues, and indices alias.
- Flags with more than one bit set, or none set, are illegal. Only cmp_gt and cmp_lt are acted on.
- Reset asserted mid-frame or mid-DONE discards the frame and any unaccepted result. No partial result is ever presented.

Optional Feature:
- Macro: MINMAX_COUNT_EN.
- Defined:
  - Adds output port out_count [IDXWIDTH:0], the number of samples in the frame. It saturates at 2^(IDXWIDTH+1)-1, is valid with out_valid, and resets to 0.
  - Adds output port out_wrap (1 bit), set when the index counter wrapped in the frame.
- Undefined: neither port exists; all other behaviour is identical.

Test Plan:
- Reset: hold Rst=0 with random inputs -> all outputs 0, in_ready=0. Release -> in_ready=1 next cycle.
- Frame 5,9,2,9,2 with last on the final sample -> out_min=2, out_min_idx=2, out_max=9, out_max_idx=1, out_valid 3 cycles after the last transfer.
- Single-sample frame 0x7F -> min=max=0x7F, both indices 0, out_valid 1 cycle after transfer.
- Backpressure: out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0. out_ready=1 -> next frame is accepted from index 0.
- Frame 0,0xFF,0,0xFF -> min=0 at idx 0, max=0xFF at idx 1; cmp_a/cmp_b match smp/max, then smp/min, in CMP states.
- Rst pulsed low during CMP_MIN of frame 3,1 -> no out_valid. Next frame 4 -> result 4/4, indices 0.

Source files
------------

// File: rtl/comp_minmax_tracker_if.sv
// Handshake bundle for comp_minmax_tracker: sample stream in, comparator link, frame result out.
// With MINMAX_COUNT_EN defined the result also carries out_count and out_wrap.
interface comp_minmax_tracker_if #(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned IDXWIDTH  = 8
);
  logic [DATAWIDTH-1:0] in_data;
  logic                 in_valid;
  logic                 in_last;
  logic                 in_ready;
  logic [DATAWIDTH-1:0] cmp_a;
  logic [DATAWIDTH-1:0] cmp_b;
  logic                 cmp_gt;
  logic                 cmp_lt;
  logic                 cmp_eq;
  logic [DATAWIDTH-1:0] out_min;
  logic [DATAWIDTH-1:0] out_max;
  logic [IDXWIDTH-1:0]  out_min_idx;
  logic [IDXWIDTH-1:0]  out_max_idx;
  logic                 out_valid;
  logic                 out_ready;
`ifdef MINMAX_COUNT_EN
  logic [IDXWIDTH:0]    out_count;
  logic                 out_wrap;
`endif

  // slave: the tracker itself; master: upstream source, COMP and downstream sink
  modport slave (
    input  in_data, in_valid, in_last, cmp_gt, cmp_lt, cmp_eq, out_ready,
    output in_ready, cmp_a, cmp_b, out_min, out_max, out_min_idx, out_max_idx, out_valid
`ifdef MINMAX_COUNT_EN
    , output out_count, out_wrap
`endif
  );

  modport master (
    output in_data, in_valid, in_last, cmp_gt, cmp_lt, cmp_eq, out_ready,
    input  in_ready, cmp_a, cmp_b, out_min, out_max, out_min_idx, out_max_idx, out_valid
`ifdef MINMAX_COUNT_EN
    , input out_count, out_wrap
`endif
  );
endinterface

// File: rtl/comp_minmax_tracker.sv
// Streaming min/max tracker sequencing one shared COMP (max compare, then min compare).
// Optional MINMAX_COUNT_EN adds out_count (saturating frame length) and out_wrap.
module comp_minmax_tracker #(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned IDXWIDTH  = 8
) (
  input logic                Clk,
  input logic                Rst,
  comp_minmax_tracker_if.slave bus
);
  typedef enum logic [1:0] {ACCEPT, CMP_MAX, CMP_MIN, DONE} state_t;

  state_t               state_q, state_d;
  logic                 armed_q;
  logic [DATAWIDTH-1:0] smp_q, smp_d, min_q, min_d, max_q, max_d;
  logic [IDXWIDTH-1:0]  idx_q, idx_d, cnt_q, cnt_d;
  logic [IDXWIDTH-1:0]  min_idx_q, min_idx_d, max_idx_q, max_idx_d;
  logic                 lst_q, lst_d, frm_q, frm_d;
  logic                 xfer, load, release_out;

  assign bus.in_ready = armed_q && (state_q == ACCEPT);
  assign xfer         = bus.in_valid && bus.in_ready;
  assign release_out  = (state_q == DONE) && bus.out_ready;
  assign load         = (state_d == DONE) && (state_q != DONE);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state_q <= ACCEPT;
    else      state_q <= state_d;
  end

  // frm_q marks "frame in progress" so a wrapped index of 0 is not mistaken for a first sample
  always_comb begin
    state_d   = state_q;
    smp_d     = smp_q;
    lst_d     = lst_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    frm_d     = frm_q;
    min_d     = min_q;
    max_d     = max_q;
    min_idx_d = min_idx_q;
    max_idx_d = max_idx_q;
    bus.cmp_a = '0;
    bus.cmp_b = '0;
    case (state_q)
      ACCEPT: begin
        if (xfer) begin
          smp_d = bus.in_data;
          lst_d = bus.in_last;
          idx_d = cnt_q;
          cnt_d = cnt_q + 1'b1;
          frm_d = 1'b1;
          if (!frm_q) begin
            min_d     = bus.in_data;
            max_d     = bus.in_data;
            min_idx_d = '0;
            max_idx_d = '0;
            state_d   = bus.in_last ? DONE : ACCEPT;
          end else begin
            state_d = CMP_MAX;
          end
        end
      end
      CMP_MAX: begin
        bus.cmp_a = smp_q;
        bus.cmp_b = max_q;
        if (bus.cmp_gt) begin
          max_d     = smp_q;
          max_idx_d = idx_q;
        end
        state_d = CMP_MIN;
      end
      CMP_MIN: begin
        bus.cmp_a = smp_q;
        bus.cmp_b = min_q;
        if (bus.cmp_lt) begin
          min_d     = smp_q;
          min_idx_d = idx_q;
        end
        state_d = lst_q ? DONE : ACCEPT;
      end
      DONE: begin
        if (bus.out_ready) begin
          cnt_d   = '0;
          frm_d   = 1'b0;
          state_d = ACCEPT;
        end
      end
      default: state_d = ACCEPT;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      armed_q         <= 1'b0;
      smp_q           <= '0;
      lst_q           <= 1'b0;
      idx_q           <= '0;
      cnt_q           <= '0;
      frm_q           <= 1'b0;
      min_q           <= '0;
      max_q           <= '0;
      min_idx_q       <= '0;
      max_idx_q       <= '0;
      bus.out_min     <= '0;
      bus.out_max     <= '0;
      bus.out_min_idx <= '0;
      bus.out_max_idx <= '0;
      bus.out_valid   <= 1'b0;
    end else begin
      armed_q   <= 1'b1;
      smp_q     <= smp_d;
      lst_q     <= lst_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      frm_q     <= frm_d;
      min_q     <= min_d;
      max_q     <= max_d;
      min_idx_q <= min_idx_d;
      max_idx_q <= max_idx_d;
      if (load) begin
        bus.out_min     <= min_d;
        bus.out_max     <= max_d;
        bus.out_min_idx <= min_idx_d;
        bus.out_max_idx <= max_idx_d;
        bus.out_valid   <= 1'b1;
      end else if (release_out) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

`ifdef MINMAX_COUNT_EN
  logic [IDXWIDTH:0] fcnt_q, fcnt_d;
  logic              wrap_q, wrap_d;

  always_comb begin
    fcnt_d = fcnt_q;
    wrap_d = wrap_q;
    if (xfer) begin
      if (fcnt_q != '1) fcnt_d = fcnt_q + 1'b1;
      if (frm_q && (cnt_q == '0)) wrap_d = 1'b1;
    end
    if (release_out) begin
      fcnt_d = '0;
      wrap_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      fcnt_q        <= '0;
      wrap_q        <= 1'b0;
      bus.out_count <= '0;
      bus.out_wrap  <= 1'b0;
    end else begin
      fcnt_q <= fcnt_d;
      wrap_q <= wrap_d;
      if (load) begin
        bus.out_count <= fcnt_d;
        bus.out_wrap  <= wrap_d;
      end
    end
  end
`endif
endmodule

// File: tb/tb_comp_minmax_tracker.sv
// Directed bench for comp_minmax_tracker with a behavioural COMP attached to cmp_a/cmp_b.
module tb_comp_minmax_tracker;
  logic Clk = 1'b0;
  logic Rst = 1'b0;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  comp_minmax_tracker_if #(.DATAWIDTH(8), .IDXWIDTH(8)) bus ();

  comp_minmax_tracker #(.DATAWIDTH(8), .IDXWIDTH(8)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus.slave)
  );

  assign bus.cmp_gt = bus.cmp_a > bus.cmp_b;
  assign bus.cmp_lt = bus.cmp_a < bus.cmp_b;
  assign bus.cmp_eq = bus.cmp_a == bus.cmp_b;

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents one sample, waits (bounded) for in_ready, returns #1 after the transfer edge
  task automatic send(input logic [7:0] d, input logic last);
    int unsigned guard;
    bus.in_data  = d;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    guard = 0;
    while (!bus.in_ready && guard < 20) begin
      step();
      guard++;
    end
    if (!bus.in_ready) chk("send_timeout", 32'd0, 32'd1);
    step();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic chk_result(input string tag, input logic [7:0] mn, input logic [7:0] mni,
                            input logic [7:0] mx, input logic [7:0] mxi);
    chk({tag, "_valid"},   bus.out_valid,   32'd1);
    chk({tag, "_min"},     bus.out_min,     mn);
    chk({tag, "_min_idx"}, bus.out_min_idx, mni);
    chk({tag, "_max"},     bus.out_max,     mx);
    chk({tag, "_max_idx"}, bus.out_max_idx, mxi);
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("drain_valid_low", bus.out_valid, 32'd0);
  endtask

  initial begin
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    // Reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      bus.in_data   = 8'($urandom);
      bus.in_valid  = 1'($urandom);
      bus.in_last   = 1'($urandom);
      bus.out_ready = 1'($urandom);
      step();
    end
    chk("rst_in_ready",    bus.in_ready,    32'd0);
    chk("rst_out_valid",   bus.out_valid,   32'd0);
    chk("rst_out_min",     bus.out_min,     32'd0);
    chk("rst_out_max",     bus.out_max,     32'd0);
    chk("rst_out_min_idx", bus.out_min_idx, 32'd0);
    chk("rst_out_max_idx", bus.out_max_idx, 32'd0);
    chk("rst_cmp_a",       bus.cmp_a,       32'd0);
    chk("rst_cmp_b",       bus.cmp_b,       32'd0);
`ifdef MINMAX_COUNT_EN
    chk("rst_out_count",   bus.out_count,   32'd0);
    chk("rst_out_wrap",    bus.out_wrap,    32'd0);
`endif
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    Rst = 1'b1;
    #1;
    chk("rel_in_ready_same", bus.in_ready, 32'd0);
    step();
    chk("rel_in_ready_next", bus.in_ready, 32'd1);

    // Frame 5,9,2,9,2
    send(8'd5, 1'b0);
    chk("f1_first_ready", bus.in_ready, 32'd1);
    send(8'd9, 1'b0);
    chk("f1_cmpmax_a", bus.cmp_a, 32'd9);
    chk("f1_cmpmax_b", bus.cmp_b, 32'd5);
    chk("f1_cmpmax_rdy", bus.in_ready, 32'd0);
    step();
    chk("f1_cmpmin_a", bus.cmp_a, 32'd9);
    chk("f1_cmpmin_b", bus.cmp_b, 32'd5);
    send(8'd2, 1'b0);
    send(8'd9, 1'b0);
    send(8'd2, 1'b1);
    chk("f1_lat0", bus.out_valid, 32'd0);
    step();
    chk("f1_lat1", bus.out_valid, 32'd0);
    step();
    chk_result("f1", 8'd2, 8'd2, 8'd9, 8'd1);
`ifdef MINMAX_COUNT_EN
    chk("f1_count", bus.out_count, 32'd5);
    chk("f1_wrap",  bus.out_wrap,  32'd0);
`endif
    chk("f1_done_cmp_a", bus.cmp_a, 32'd0);

    // Backpressure: result held, input stalled
    bus.in_data  = 8'hAA;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_valid",    bus.out_valid,   32'd1);
      chk("bp_in_ready", bus.in_ready,    32'd0);
      chk("bp_min",      bus.out_min,     32'd2);
      chk("bp_max_idx",  bus.out_max_idx, 32'd1);
    end
    bus.in_valid = 1'b0;
    drain();
    chk("post_drain_ready", bus.in_ready, 32'd1);

    // Single-sample frame
    send(8'h7F, 1'b1);
    chk_result("single", 8'h7F, 8'd0, 8'h7F, 8'd0);
    drain();

    // Frame 0,FF,0,FF
    send(8'h00, 1'b0);
    send(8'hFF, 1'b0);
    chk("f3_s1_max_a", bus.cmp_a, 32'hFF);
    chk("f3_s1_max_b", bus.cmp_b, 32'h00);
    step();
    chk("f3_s1_min_a", bus.cmp_a, 32'hFF);
    chk("f3_s1_min_b", bus.cmp_b, 32'h00);
    send(8'h00, 1'b0);
    chk("f3_s2_max_a", bus.cmp_a, 32'h00);
    chk("f3_s2_max_b", bus.cmp_b, 32'hFF);
    step();
    chk("f3_s2_min_a", bus.cmp_a, 32'h00);
    chk("f3_s2_min_b", bus.cmp_b, 32'h00);
    send(8'hFF, 1'b1);
    step();
    step();
    chk_result("f3", 8'h00, 8'd0, 8'hFF, 8'd1);
    drain();

    // Reset during CMP_MIN of frame 3,1
    send(8'd3, 1'b0);
    send(8'd1, 1'b1);
    step();
    chk("rm_in_cmpmin_a", bus.cmp_a, 32'd1);
    Rst = 1'b0;
    #2;
    chk("rm_valid_rst", bus.out_valid, 32'd0);
    chk("rm_ready_rst", bus.in_ready,  32'd0);
    step();
    Rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rm_no_valid", bus.out_valid, 32'd0);
    end
    send(8'd4, 1'b1);
    chk_result("rm_next", 8'd4, 8'd0, 8'd4, 8'd0);
    drain();

    // 258-sample frame: index wraps, minimum stays at 100, maximum aliases to index 1
    for (int i = 0; i < 258; i++) begin
      send((i == 100) ? 8'd0 : (i == 257) ? 8'd200 : 8'd10, i == 257);
    end
    step();
    step();
    chk_result("wrap", 8'd0, 8'd100, 8'd200, 8'd1);
`ifdef MINMAX_COUNT_EN
    chk("wrap_count", bus.out_count, 32'd258);
    chk("wrap_flag",  bus.out_wrap,  32'd1);
`endif
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
